// File: rtl/cam_match_encoder_if.sv
// Address stream from the CAM match encoder to its consumer.
// The master drives addresses and the slave returns ready.
interface cam_match_encoder_if #(
    parameter int ADDR_WIDTH = 4
);
    logic                  m_valid;
    logic                  m_ready;
    logic [ADDR_WIDTH-1:0] m_addr;
    logic                  m_last;

    modport master (output m_valid, output m_addr, output m_last, input m_ready);
    modport slave  (input m_valid, input m_addr, input m_last, output m_ready);
endinterface

// File: rtl/cam_match_encoder.sv
// Captures a CAM match bitmap and streams the address of every set bit,
// lowest address first, with hit/count/done status for the lookup controller.
module cam_match_encoder #(
    parameter  int ADDR_WIDTH = 4,
    localparam int VEC_W      = 2**ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [VEC_W-1:0]      match_vec,
    output logic                  busy,
    output logic                  hit,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  done,
    cam_match_encoder_if.master   m
);
    typedef enum logic [1:0] {IDLE, EMIT, DONE} state_t;

    state_t                  state;
    logic [VEC_W-1:0]        pending;
    logic [ADDR_WIDTH-1:0]   low_idx;
    logic                    single;
    logic                    emit;

    // The extra count bit covers the all-ones vector.
    function automatic logic [ADDR_WIDTH:0] popcount(input logic [VEC_W-1:0] v);
        logic [ADDR_WIDTH:0] c;
        c = '0;
        for (int i = 0; i < VEC_W; i++)
            c = c + {{ADDR_WIDTH{1'b0}}, v[i]};
        return c;
    endfunction

    // Descending scan so the lowest set bit is the last one written.
    always_comb begin
        low_idx = '0;
        for (int i = VEC_W - 1; i >= 0; i--)
            if (pending[i])
                low_idx = ADDR_WIDTH'(i);
    end

    assign single = (pending != '0) && ((pending & (pending - VEC_W'(1))) == '0);
    assign emit   = (state == EMIT);

    // Stream outputs decode only from state and pending, never from inputs.
    assign m.m_valid = emit;
    assign m.m_addr  = emit ? low_idx : '0;
    assign m.m_last  = emit & single;
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            pending <= '0;
            hit     <= 1'b0;
            count   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        pending <= match_vec;
                        count   <= popcount(match_vec);
                        hit     <= (match_vec != '0);
                        state   <= (match_vec != '0) ? EMIT : DONE;
                    end
                end
                EMIT: begin
                    if (abort) begin
                        pending <= '0;
                        state   <= IDLE;
                    end else if (m.m_ready) begin
                        // Clearing the lowest set bit retires the address on the bus.
                        pending <= pending & (pending - VEC_W'(1));
                        if (single)
                            state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_cam_match_encoder.sv
// Randomised bench for cam_match_encoder against a queue-of-addresses model.
module tb_cam_match_encoder;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic [15:0] match_vec;
    logic        busy;
    logic        hit;
    logic [4:0]  count;
    logic        done;
    int          n_chk  = 0;
    int          n_pass = 0;

    cam_match_encoder_if #(.ADDR_WIDTH(4)) bus ();

    cam_match_encoder #(.ADDR_WIDTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .match_vec (match_vec),
        .busy      (busy),
        .hit       (hit),
        .count     (count),
        .done      (done),
        .m         (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic rnd_ready(input bit rnd);
        return rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
    endfunction

    // Model: the expected stream is simply the set-bit indices in ascending order.
    task automatic run_encode(input logic [15:0] vec, input int hold0, input bit rnd, input int abort_at);
        int q[$];
        int cnt;
        int nhs;
        int cyc;
        logic hs;
        for (int i = 0; i < 16; i++)
            if (vec[i]) q.push_back(i);
        cnt = q.size();

        start     = 1'b1;
        match_vec = vec;
        abort     = 1'($urandom_range(0, 1));
        tick();
        start     = 1'b0;
        abort     = 1'b0;
        match_vec = 16'($urandom);
        chk("busy_after_start", 32'(busy), 32'(1));
        chk("hit", 32'(hit), 32'(cnt != 0));
        chk("count", 32'(count), 32'(cnt));

        if (cnt == 0) begin
            chk("zero_valid", 32'(bus.m_valid), 32'(0));
            chk("zero_done", 32'(done), 32'(1));
            tick();
            chk("zero_done_clr", 32'(done), 32'(0));
            chk("zero_busy_clr", 32'(busy), 32'(0));
            return;
        end

        nhs = 0;
        cyc = 0;
        bus.m_ready = (hold0 > 0) ? 1'b0 : rnd_ready(rnd);
        forever begin
            chk("valid", 32'(bus.m_valid), 32'(1));
            chk("addr", 32'(bus.m_addr), 32'(q[0]));
            chk("last", 32'(bus.m_last), 32'(q.size() == 1));
            chk("done_early", 32'(done), 32'(0));
            if (nhs == abort_at) begin
                abort = 1'b1;
                tick();
                abort = 1'b0;
                bus.m_ready = 1'b0;
                chk("abort_valid", 32'(bus.m_valid), 32'(0));
                chk("abort_busy", 32'(busy), 32'(0));
                chk("abort_done", 32'(done), 32'(0));
                chk("abort_count", 32'(count), 32'(cnt));
                chk("abort_hit", 32'(hit), 32'(1));
                tick();
                chk("abort_no_late_done", 32'(done), 32'(0));
                return;
            end
            hs = bus.m_ready;
            if ($urandom_range(0, 7) == 0) begin
                start     = 1'b1;
                match_vec = 16'($urandom);
            end
            tick();
            start = 1'b0;
            cyc++;
            if (hs) begin
                void'(q.pop_front());
                nhs++;
            end
            if (q.size() == 0) break;
            if (cyc > 300) begin
                chk("cycle_budget", 32'(cyc), 32'(0));
                return;
            end
            bus.m_ready = (cyc < hold0) ? 1'b0 : rnd_ready(rnd);
        end

        chk("done_pulse", 32'(done), 32'(1));
        chk("done_valid", 32'(bus.m_valid), 32'(0));
        chk("done_busy", 32'(busy), 32'(1));
        bus.m_ready = rnd_ready(rnd);
        tick();
        chk("done_clr", 32'(done), 32'(0));
        chk("idle_busy", 32'(busy), 32'(0));
        chk("hold_hit", 32'(hit), 32'(1));
        chk("hold_count", 32'(count), 32'(cnt));
    endtask

    initial begin
        rst         = 1'b1;
        start       = 1'b0;
        abort       = 1'b0;
        match_vec   = '0;
        bus.m_ready = 1'b0;
        tick();
        tick();
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_hit", 32'(hit), 32'(0));
        chk("rst_count", 32'(count), 32'(0));
        chk("rst_valid", 32'(bus.m_valid), 32'(0));
        chk("rst_addr", 32'(bus.m_addr), 32'(0));
        chk("rst_last", 32'(bus.m_last), 32'(0));
        chk("rst_done", 32'(done), 32'(0));
        rst = 1'b0;

        // Abort alone in IDLE does nothing.
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("idle_abort_busy", 32'(busy), 32'(0));

        run_encode(16'h8421, 0, 1'b0, -1);
        run_encode(16'h0000, 0, 1'b0, -1);
        run_encode(16'h0006, 3, 1'b0, -1);
        run_encode(16'hFFFF, 0, 1'b0, -1);
        run_encode(16'h00F0, 0, 1'b0, 2);
        run_encode(16'h0100, 0, 1'b0, -1);
        // Abort coincident with the final handshake must win.
        run_encode(16'h0081, 0, 1'b0, 1);

        // Reset in the middle of an emission.
        start       = 1'b1;
        match_vec   = 16'h0300;
        bus.m_ready = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("pre_rst_addr", 32'(bus.m_addr), 32'(9));
        rst = 1'b1;
        tick();
        chk("mid_rst_valid", 32'(bus.m_valid), 32'(0));
        chk("mid_rst_addr", 32'(bus.m_addr), 32'(0));
        chk("mid_rst_last", 32'(bus.m_last), 32'(0));
        chk("mid_rst_busy", 32'(busy), 32'(0));
        chk("mid_rst_hit", 32'(hit), 32'(0));
        chk("mid_rst_count", 32'(count), 32'(0));
        chk("mid_rst_done", 32'(done), 32'(0));
        rst = 1'b0;
        tick();
        chk("post_rst_done", 32'(done), 32'(0));
        run_encode(16'h0300, 0, 1'b1, -1);

        for (int t = 0; t < 40; t++) begin
            logic [15:0] v;
            v = 16'($urandom);
            if (t % 8 == 0) v = '0;
            run_encode(v, int'($urandom_range(0, 2)), 1'b1,
                       (t % 5 == 0) ? int'($urandom_range(0, 3)) : -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/cam_match_encoder.md
Name: cam_match_encoder

Overview:
- Sits directly downstream of the CAM match RAM.
- Captures the one-hot-per-address match bitmap returned for a lookup key.
- Serialises every set bit into an address stream, lowest address first, over a valid/ready handshake.
- Reports hit, match count and completion to the lookup controller.

Parameters:
- ADDR_WIDTH, 4, width of a CAM address. The match vector width is 2**ADDR_WIDTH and is derived internally; it is not overridable.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset.
- start  in  1  capture match_vec and begin encoding; honoured only in IDLE.
- abort  in  1  drop the current encode and return to IDLE, no done pulse.
- match_vec  in  2**ADDR_WIDTH  match bitmap; bit i set means address i holds the key.
- busy  out  1  high in any state other than IDLE.
- hit  out  1  latched: the captured vector was non-zero.
- count  out  ADDR_WIDTH+1  latched popcount of the captured vector.
- m_valid  out  1  m_addr is valid.
- m_ready  in  1  consumer accepts m_addr.
- m_addr  out  ADDR_WIDTH  current matching address.
- m_last  out  1  m_addr is the final match of this vector.
- done  out  1  one-cycle pulse when the encode completes.

Behaviour:
- Reset: rst is synchronous, active-high. It forces state IDLE and pending=0, and drives busy, hit, count, m_valid, m_addr, m_last and done to 0. It takes priority over start, abort and handshake.
- Reset mid-emission: all outputs are 0 after the next edge, with no done pulse.
- The FSM has three states: IDLE, EMIT and DONE.
- IDLE:
  - On start: pending <= match_vec; count <= popcount(match_vec); hit <= (match_vec != 0).
  - If match_vec is non-zero, go to EMIT. Otherwise go to DONE.
- EMIT:
  - m_valid=1.
  - m_addr = index of the lowest set bit of pending.
  - m_last = 1 when pending has exactly one bit set.
  - m_addr and m_last are decoded from registered state only; there is no combinational path from the inputs.
  - On m_valid && m_ready: clear that bit in pending. If m_last, go to DONE; else stay in EMIT and present the next-lowest address in the following cycle.
  - Throughput is one address per cycle while m_ready=1.
  - With m_ready=0, m_addr and m_last are held stable and m_valid stays 1.
- DONE:
  - done=1 for exactly one cycle, then IDLE.
  - busy=1 in DONE.
- Latency:
  - start at edge N gives m_valid high after edge N+1.
  - For a zero vector, done is high after edge N+1.
  - For a non-zero vector, done is high in the cycle after the final handshake.
- start outside IDLE is ignored; the capture registers are not updated.
- abort in EMIT or DONE goes to IDLE next edge and drops m_valid. done does not pulse. hit and count keep their latched values.
  - abort together with a final handshake: abort wins, no done pulse.
  - abort in IDLE has no effect.
  - abort and start together in IDLE: start is honoured.
- hit and count hold their values until the next accepted start.
- count spans 0..2**ADDR_WIDTH inclusive. An all-ones vector gives count = 2**ADDR_WIDTH and needs the extra bit.
- match_vec is sampled only on the start edge; later changes have no effect.
- The upstream RAM updates its output on the falling edge, so match_vec is stable at every rising edge.

Test Plan:
1. ADDR_WIDTH=4, start with match_vec=0x8421, m_ready=1 -> m_addr 0,5,10,15 on four consecutive cycles; m_last only with 15; count=4, hit=1; done one cycle after the addr-15 handshake.
2. start with match_vec=0x0000 -> m_valid never rises; hit=0, count=0; done pulses once after edge N+1; busy high for one cycle.
3. match_vec=0x0006, m_ready held 0 for 3 cycles -> m_addr=1 stable with m_valid=1 throughout; after m_ready=1, addresses 1 then 2, m_last on 2.
4. match_vec=0xFFFF -> count=16 (5'b10000), 16 addresses 0..15 in order; a second start with 0x0001 mid-stream is ignored and count stays 16.
5. match_vec=0x00F0, abort asserted after the addr-5 handshake -> IDLE next edge, m_valid=0, no done pulse, count stays 4; a fresh start with 0x0100 emits address 8.
6. rst asserted during EMIT with match_vec=0x0300 -> all outputs 0 after the next edge, no done pulse; start after rst release works normally.
